rtc_snapshot_ctrl: RTL and testbench
====================================

// Module: rtc_snapshot_ctrl
// PURPOSE
//  Sequences reads of the RTC/timer register bank during VGA vertical blanking.
//  Fetches NUM_REGS bytes over a req/ack read port into a shadow buffer.
//  Publishes them atomically as a coherent snapshot for the display formatter.
//  The display never sees a frame built from half-updated time/date values.
// PARAMETERS
//  NUM_REGS     11   registers fetched per frame (addresses 0..NUM_REGS-1)
//  ADDR_W       4    width of rd_addr; 2**ADDR_W >= NUM_REGS
//  VBLANK_LINE  480  first pixely value counted as blanking
//  ACK_TIMEOUT  255  max cycles rd_req may wait for rd_ack before abort (<=255)
// PORTS
//  clk        in   1            system clock; every register on posedge
//  reset      in   1            asynchronous, active-low reset
//  pixely     in   10           current VGA line from the sync generator
//  bus_busy   in   1            RTC bus owned by the write/programming path
//  rd_req     out  1            read request; held with rd_addr stable until ack
//  rd_addr    out  ADDR_W       register index being read
//  rd_ack     in   1            1-cycle strobe; rd_data valid in the same cycle
//  rd_data    in   8            BCD byte returned by the RTC interface
//  snap_data  out  NUM_REGS*8   published snapshot; byte k at [8k+7:8k]
//  snap_valid out  1            1-cycle pulse on every publish
//  snap_err   out  1            1-cycle pulse when a frame's fetch is aborted
//  busy       out  1            high from leaving IDLE until return to IDLE
// BEHAVIOUR
//  Reset (reset=0): rd_req=0, rd_addr=0, snap_data=0, snap_valid=0, snap_err=0,
//   busy=0, shadow=0, FSM=IDLE, vb_r=0. The reset clears snap_data.
//  vb = (pixely >= VBLANK_LINE). vb_r is vb registered.
//   start = vb & ~vb_r (rising edge). start is not raised while in vblank out of reset.
//  FSM states:
//   IDLE: on start -> WAIT_BUS; idx<=0; busy<=1.
//   WAIT_BUS: if !vb -> ABORT; else if !bus_busy -> REQ (rd_req<=1, rd_addr<=idx, tmo<=0).
//   REQ: rd_req=1.
//    If rd_ack: shadow[idx]<=rd_data; rd_req<=0.
//     Then: if idx==NUM_REGS-1 -> COMMIT; else idx<=idx+1 -> WAIT_BUS.
//    Else if tmo==ACK_TIMEOUT: rd_req<=0 -> ABORT.
//    Else tmo<=tmo+1.
//    A read in flight completes even if vb or bus_busy falls.
//    rd_ack wins over timeout on the same cycle.
//   COMMIT: snap_data<=shadow (all bytes same edge); snap_valid<=1 -> DONE.
//   ABORT: snap_err<=1; snap_data unchanged -> DONE.
//   DONE: busy<=0 -> IDLE. A new start is required, so there is at most one
//    fetch per frame.
//  Handshake timing:
//   rd_req drops the cycle after ack.
//   rd_req is low for at least 1 cycle between reads (WAIT_BUS).
//   rd_ack seen while rd_req=0 is ignored.
//  Latency, no contention, ack one cycle after req: 3 cycles per byte.
//   snap_valid follows start by 3*NUM_REGS+1 cycles.
//  Arithmetic:
//   idx is ADDR_W bits and never exceeds NUM_REGS-1 (no wrap).
//   tmo is 8 bits and saturates via the compare.
//  Simultaneous events:
//   start is ignored outside IDLE.
//   bus_busy rising during REQ has no effect until the next WAIT_BUS.
//  Reset mid-operation returns all state to reset values at once.
//   rd_req falls asynchronously. A partial shadow is never published.
// TESTING
//  T1 Nominal: pixely 479->480, ack 1 cycle after each req, rd_data=0x10+k
//   -> 11 reads, addr 0..10 in order; one snap_valid; snap_data byte k=0x10+k.
//  T2 Contention: bus_busy=1 for 20 cycles at byte 4
//   -> rd_req stays low and rd_addr is not advanced; resumes at addr 4;
//   snapshot correct.
//  T3 Vblank ends mid-fetch: pixely->0 during WAIT_BUS before byte 6
//   -> snap_err pulse, no snap_valid, snap_data equals previous frame.
//  T4 Timeout: no rd_ack at addr 2 -> rd_req drops after 256 REQ cycles;
//   snap_err=1 for 1 cycle; busy=0 two cycles later.
//  T5 Reset mid-fetch: reset=0 at byte 7 -> rd_req=0 and snap_data=0
//   immediately; no snap_valid after release until the next vblank edge.
//  T6 Ack/timeout tie: rd_ack on the tmo==255 cycle -> byte accepted,
//   no snap_err, fetch continues.

Source files
------------

// File: rtl/rtc_snapshot_ctrl.sv
// rtc_snapshot_ctrl
// Fetches the RTC/timer register bank once per VGA vertical blanking interval
// into a shadow buffer and publishes it as one coherent snapshot, so the
// display formatter never renders a mix of old and new time/date bytes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for the rising edge of vertical blanking
// WAIT_BUS | between reads; waits for the RTC bus, aborts if vblank ends
// REQ      | rd_req held with rd_addr stable until rd_ack or timeout
// COMMIT   | all bytes fetched; shadow copied to snap_data in one edge
// ABORT    | fetch abandoned; snap_data keeps the previous snapshot
// DONE     | one-cycle tail that drops busy before returning to IDLE

module rtc_snapshot_ctrl #(
    parameter int NUM_REGS    = 11,
    parameter int ADDR_W      = 4,
    parameter int VBLANK_LINE = 480,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            pixely,
    input  logic                  bus_busy,
    output logic                  rd_req,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_ack,
    input  logic [7:0]            rd_data,
    output logic [NUM_REGS*8-1:0] snap_data,
    output logic                  snap_valid,
    output logic                  snap_err,
    output logic                  busy
);

    localparam logic [9:0]        VB_LINE  = 10'(VBLANK_LINE);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [7:0]        TMO_MAX  = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_REQ,
        S_COMMIT,
        S_ABORT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                  vb, vb_r, vb_armed, start;
    logic [ADDR_W-1:0]     idx, idx_nxt;
    logic [7:0]            tmo, tmo_nxt;
    logic [NUM_REGS*8-1:0] shadow;

    logic                  rd_req_nxt;
    logic [ADDR_W-1:0]     rd_addr_nxt;
    logic                  busy_nxt;
    logic                  snap_valid_nxt;
    logic                  snap_err_nxt;
    logic                  shadow_we;
    logic                  commit;

    // vb_armed keeps a reset released in the middle of blanking from being
    // mistaken for a blanking edge: a line outside vblank must be seen first.
    assign vb    = (pixely >= VB_LINE);
    assign start = vb & ~vb_r & vb_armed;

    // Blanking edge detector registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vb_r     <= 1'b0;
            vb_armed <= 1'b0;
        end else begin
            vb_r <= vb;
            if (!vb)
                vb_armed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_WAIT_BUS;
            end
            S_WAIT_BUS: begin
                if (!vb)
                    state_nxt = S_ABORT;
                else if (!bus_busy)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                // An ack on the final timeout cycle still counts as success.
                if (rd_ack)
                    state_nxt = (idx == IDX_LAST) ? S_COMMIT : S_WAIT_BUS;
                else if (tmo == TMO_MAX)
                    state_nxt = S_ABORT;
            end
            S_COMMIT: state_nxt = S_DONE;
            S_ABORT:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next-value decode.
    always_comb begin
        rd_req_nxt     = rd_req;
        rd_addr_nxt    = rd_addr;
        idx_nxt        = idx;
        tmo_nxt        = tmo;
        busy_nxt       = busy;
        snap_valid_nxt = 1'b0;
        snap_err_nxt   = 1'b0;
        shadow_we      = 1'b0;
        commit         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nxt  = '0;
                    busy_nxt = 1'b1;
                end
            end
            S_WAIT_BUS: begin
                if (vb && !bus_busy) begin
                    rd_req_nxt  = 1'b1;
                    rd_addr_nxt = idx;
                    tmo_nxt     = '0;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    shadow_we  = 1'b1;
                    rd_req_nxt = 1'b0;
                    if (idx != IDX_LAST)
                        idx_nxt = idx + 1'b1;
                end else if (tmo == TMO_MAX) begin
                    rd_req_nxt = 1'b0;
                end else begin
                    tmo_nxt = tmo + 8'd1;
                end
            end
            S_COMMIT: begin
                commit         = 1'b1;
                snap_valid_nxt = 1'b1;
            end
            S_ABORT: begin
                snap_err_nxt = 1'b1;
            end
            S_DONE: begin
                busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Handshake, counters and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            idx        <= '0;
            tmo        <= '0;
            busy       <= 1'b0;
            snap_valid <= 1'b0;
            snap_err   <= 1'b0;
        end else begin
            rd_req     <= rd_req_nxt;
            rd_addr    <= rd_addr_nxt;
            idx        <= idx_nxt;
            tmo        <= tmo_nxt;
            busy       <= busy_nxt;
            snap_valid <= snap_valid_nxt;
            snap_err   <= snap_err_nxt;
        end
    end

    // Shadow capture per byte; publish copies the whole buffer at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow    <= '0;
            snap_data <= '0;
        end else begin
            if (shadow_we) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (idx == ADDR_W'(k))
                        shadow[k*8 +: 8] <= rd_data;
                end
            end
            if (commit)
                snap_data <= shadow;
        end
    end

endmodule

// File: tb/tb_rtc_snapshot_ctrl.sv
// Directed bench for rtc_snapshot_ctrl: a scripted RTC read port answers each
// request after a programmable delay; a monitor logs request addresses and
// pulse timings, and the main sequence compares them to hand-derived values.

module tb_rtc_snapshot_ctrl;

    localparam int NUM_REGS = 11;
    localparam int ADDR_W   = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [9:0]            pixely = 10'd0;
    logic                  bus_busy = 1'b0;
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_ack = 1'b0;
    logic [7:0]            rd_data = 8'h00;
    logic [NUM_REGS*8-1:0] snap_data;
    logic                  snap_valid;
    logic                  snap_err;
    logic                  busy;

    rtc_snapshot_ctrl #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .VBLANK_LINE (480),
        .ACK_TIMEOUT (255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pixely     (pixely),
        .bus_busy   (bus_busy),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .snap_err   (snap_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Read-port responder settings, written only by the main sequence.
    logic [7:0] ack_base  = 8'h00;
    int         ack_lat   = 1;
    int         slow_addr = -1;
    int         slow_lat  = 1;

    // Monitor results, written only by the monitor.
    int cyc = 0;
    int valid_cnt = 0, err_cnt = 0;
    int valid_len = 0, err_len = 0;
    int valid_rise_cyc = 0, err_rise_cyc = 0;
    int busy_rise_cyc = 0, busy_fall_cyc = 0;
    int req_len = 0, last_req_len = 0, req_fall_cyc = 0;
    int log_n = 0;
    int rd_log [512];

    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*8-1:0] exp_snap(input logic [7:0] base);
        logic [NUM_REGS*8-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_REGS; k++)
            s[k*8 +: 8] = base + 8'(k);
        return s;
    endfunction

    // Read-port responder: ack arrives `lat` cycles after rd_req is first seen.
    initial begin : responder
        int  cnt;
        bit  sent;
        int  lat;
        cnt  = 0;
        sent = 1'b0;
        forever begin
            @(negedge clk);
            rd_ack = 1'b0;
            if (!rd_req) begin
                cnt  = 0;
                sent = 1'b0;
            end else if (!sent) begin
                lat = (int'(rd_addr) == slow_addr) ? slow_lat : ack_lat;
                if (cnt == lat) begin
                    rd_ack  = 1'b1;
                    rd_data = ack_base + 8'(rd_addr);
                    sent    = 1'b1;
                end
                cnt++;
            end
        end
    end

    // Monitor: pulse counts/widths, request address log, edge timestamps.
    initial begin : monitor
        logic p_valid, p_err, p_req, p_busy;
        p_valid = 1'b0;
        p_err   = 1'b0;
        p_req   = 1'b0;
        p_busy  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (snap_valid) begin
                if (!p_valid) begin
                    valid_cnt++;
                    valid_rise_cyc = cyc;
                    valid_len = 0;
                end
                valid_len++;
            end
            if (snap_err) begin
                if (!p_err) begin
                    err_cnt++;
                    err_rise_cyc = cyc;
                    err_len = 0;
                end
                err_len++;
            end
            if (rd_req && !p_req) begin
                if (log_n < 512)
                    rd_log[log_n] = int'(rd_addr);
                log_n++;
                req_len = 0;
            end
            if (rd_req)
                req_len++;
            if (!rd_req && p_req) begin
                last_req_len = req_len;
                req_fall_cyc = cyc;
            end
            if (busy && !p_busy)
                busy_rise_cyc = cyc;
            if (!busy && p_busy)
                busy_fall_cyc = cyc;
            p_valid = snap_valid;
            p_err   = snap_err;
            p_req   = rd_req;
            p_busy  = busy;
        end
    end

    task automatic frame_start();
        pixely = 10'd479;
        repeat (3) @(negedge clk);
        pixely = 10'd480;
    endtask

    task automatic wait_req_addr(input string tag, input int a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (rd_req && int'(rd_addr) == a)
                found = 1'b1;
        end
        check_val(tag, 96'(found), 96'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            if (!busy)
                idle = 1'b1;
        end
        check_val(tag, 96'(idle), 96'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reads(input string tag, input int first, input int n);
        check_val({tag, "_nreads"}, 96'(log_n - first), 96'(n));
        for (int k = 0; k < n; k++)
            check_val({tag, "_addr"}, 96'(rd_log[first + k]), 96'(k));
    endtask

    initial begin : main
        int v0, e0, l0;
        logic [NUM_REGS*8-1:0] prev_snap;

        repeat (3) @(negedge clk);
        check_val("rst_rd_req",     96'(rd_req),     96'd0);
        check_val("rst_rd_addr",    96'(rd_addr),    96'd0);
        check_val("rst_snap_data",  96'(snap_data),  96'd0);
        check_val("rst_snap_valid", 96'(snap_valid), 96'd0);
        check_val("rst_snap_err",   96'(snap_err),   96'd0);
        check_val("rst_busy",       96'(busy),       96'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // T1 nominal frame
        ack_base = 8'h10;
        v0 = valid_cnt; e0 = err_cnt; l0 = log_n;
        frame_start();
        wait_req_addr("t1_req0", 0);
        wait_idle("t1_idle");
        repeat (40) @(negedge clk);
        check_val("t1_valid_cnt", 96'(valid_cnt - v0), 96'd1);
        check_val("t1_err_cnt",   96'(err_cnt - e0),   96'd0);
        check_reads("t1", l0, NUM_REGS);
        check_val("t1_snap",      96'(snap_data), 96'(exp_snap(8'h10)));
        check_val("t1_latency",   96'(valid_rise_cyc - busy_rise_cyc), 96'd34);
        check_val("t1_valid_len", 96'(valid_len), 96'd1);
        prev_snap = exp_snap(8'h10);

        // T2 bus contention before byte 4
        ack_base = 8'h20;
        v0 = valid_cnt; e0 = err_cnt; l0 = log_n;
        frame_start();
        wait_req_addr("t2_req3", 3);
        bus_busy = 1'b1;
        repeat (20) @(negedge clk);
        check_val("t2_stall_req",   96'(rd_req),      96'd0);
        check_val("t2_stall_addr",  96'(rd_addr),     96'd3);
        check_val("t2_stall_reads", 96'(log_n - l0),  96'd4);
        bus_busy = 1'b0;
        wait_idle("t2_idle");
        check_val("t2_valid_cnt", 96'(valid_cnt - v0), 96'd1);
        check_val("t2_err_cnt",   96'(err_cnt - e0),   96'd0);
        check_reads("t2", l0, NUM_REGS);
        check_val("t2_snap", 96'(snap_data), 96'(exp_snap(8'h20)));
        prev_snap = exp_snap(8'h20);

        // T3 vblank ends in WAIT_BUS before byte 6
        ack_base = 8'h30;
        v0 = valid_cnt; e0 = err_cnt; l0 = log_n;
        frame_start();
        wait_req_addr("t3_req5", 5);
        for (int i = 0; i < 10 && rd_req; i++)
            @(negedge clk);
        check_val("t3_req_drop", 96'(rd_req), 96'd0);
        pixely = 10'd0;
        wait_idle("t3_idle");
        check_val("t3_err_cnt",   96'(err_cnt - e0),   96'd1);
        check_val("t3_valid_cnt", 96'(valid_cnt - v0), 96'd0);
        check_val("t3_err_len",   96'(err_len), 96'd1);
        check_reads("t3", l0, 6);
        check_val("t3_snap_kept", 96'(snap_data), 96'(prev_snap));

        // T4 no ack at address 2
        ack_base  = 8'h40;
        slow_addr = 2;
        slow_lat  = 100000;
        v0 = valid_cnt; e0 = err_cnt; l0 = log_n;
        frame_start();
        wait_req_addr("t4_req2", 2);
        wait_idle("t4_idle");
        check_val("t4_err_cnt",   96'(err_cnt - e0),   96'd1);
        check_val("t4_valid_cnt", 96'(valid_cnt - v0), 96'd0);
        check_val("t4_req_len",   96'(last_req_len), 96'd256);
        check_val("t4_err_delay", 96'(err_rise_cyc - req_fall_cyc), 96'd1);
        check_val("t4_err_len",   96'(err_len), 96'd1);
        check_val("t4_busy_fall", 96'(busy_fall_cyc - req_fall_cyc), 96'd2);
        check_reads("t4", l0, 3);
        check_val("t4_snap_kept", 96'(snap_data), 96'(prev_snap));

        // T6 ack on the last timeout cycle
        ack_base = 8'h50;
        slow_lat = 255;
        v0 = valid_cnt; e0 = err_cnt; l0 = log_n;
        frame_start();
        wait_req_addr("t6_req0", 0);
        wait_idle("t6_idle");
        check_val("t6_err_cnt",   96'(err_cnt - e0),   96'd0);
        check_val("t6_valid_cnt", 96'(valid_cnt - v0), 96'd1);
        check_reads("t6", l0, NUM_REGS);
        check_val("t6_snap", 96'(snap_data), 96'(exp_snap(8'h50)));
        slow_addr = -1;

        // T5 reset at byte 7, released while still in vblank
        ack_base = 8'h60;
        frame_start();
        wait_req_addr("t5_req7", 7);
        #1;
        reset = 1'b0;
        #1;
        check_val("t5_rst_req",  96'(rd_req),    96'd0);
        check_val("t5_rst_snap", 96'(snap_data), 96'd0);
        check_val("t5_rst_busy", 96'(busy),      96'd0);
        check_val("t5_rst_addr", 96'(rd_addr),   96'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        v0 = valid_cnt; e0 = err_cnt;
        repeat (60) @(negedge clk);
        check_val("t5_no_valid", 96'(valid_cnt - v0), 96'd0);
        check_val("t5_no_err",   96'(err_cnt - e0),   96'd0);
        check_val("t5_no_busy",  96'(busy),           96'd0);
        check_val("t5_snap_clr", 96'(snap_data),      96'd0);

        ack_base = 8'h70;
        v0 = valid_cnt; l0 = log_n;
        frame_start();
        wait_req_addr("t5b_req0", 0);
        wait_idle("t5b_idle");
        check_val("t5b_valid_cnt", 96'(valid_cnt - v0), 96'd1);
        check_reads("t5b", l0, NUM_REGS);
        check_val("t5b_snap", 96'(snap_data), 96'(exp_snap(8'h70)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
